// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
//   In-order tracking queue for gshare-predicted branches. Fetch enqueues every
//   predicted branch with its prediction context. The M-stage resolves the
//   oldest branch. The block then emits the PHT training request, a GHR repair
//   value and a front-end redirect/flush when the prediction was wrong.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   enq_*                      branch entry from fetch; enq_ready = accept
//   squash                     exception flush, drops everything in flight
//   res_*                      resolution of the oldest branch from M
//   mispredict, redirect_pc    registered mispredict pulse and correct fetch PC
//   upd_*                      registered PHT training pulse
//   ghr_restore_valid/_restore registered GHR repair pulse and value
//   flush_front                high while recovering from a mispredict
//   occupancy                  live entry count
//   order_err                  sticky resolve-protocol error
module branch_resolve_queue #(
  parameter int PHT_DEPTH      = 6,
  parameter int QAW            = 2,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enq_valid,
  input  logic [31:0]          enq_pc,
  input  logic                 enq_pred_take,
  input  logic [31:0]          enq_pred_target,
  input  logic [PHT_DEPTH-1:0] enq_pht_index,
  input  logic [PHT_DEPTH-1:0] enq_ghr,
  output logic                 enq_ready,
  input  logic                 squash,
  input  logic                 res_valid,
  input  logic [31:0]          res_pc,
  input  logic                 res_take,
  input  logic [31:0]          res_target,
  output logic                 mispredict,
  output logic [31:0]          redirect_pc,
  output logic                 upd_valid,
  output logic [PHT_DEPTH-1:0] upd_pht_index,
  output logic                 upd_take,
  output logic                 ghr_restore_valid,
  output logic [PHT_DEPTH-1:0] ghr_restore,
  output logic                 flush_front,
  output logic [QAW:0]         occupancy,
  output logic                 order_err
);

  localparam int DEPTH = 1 << QAW;
  localparam int CW    = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  typedef struct packed {
    logic [31:0]          pc;
    logic                 pred_take;
    logic [31:0]          pred_target;
    logic [PHT_DEPTH-1:0] pht_index;
    logic [PHT_DEPTH-1:0] ghr;
  } entry_t;

  typedef enum logic {NORMAL, RECOVER} state_t;

  entry_t         mem [DEPTH];
  logic [QAW:0]   wr_ptr, rd_ptr;
  logic [QAW-1:0] rd_idx;
  state_t         state;
  logic [CW-1:0]  cnt;
  logic           rst_done;   // holds enq_ready low until the first edge after reset

  logic full, empty, do_res, do_enq, mis, err;

  assign rd_idx = rd_ptr[QAW-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[QAW] != rd_ptr[QAW]) && (wr_ptr[QAW-1:0] == rd_ptr[QAW-1:0]);

  assign enq_ready   = rst_done && !full && (state == NORMAL);
  assign occupancy   = wr_ptr - rd_ptr;
  assign flush_front = (state == RECOVER);

  // squash outranks everything; a resolve only acts on a live head in NORMAL
  assign do_res = res_valid && !squash && !empty && (state == NORMAL);
  assign mis    = do_res && ((mem[rd_idx].pred_take != res_take) ||
                             (res_take && (mem[rd_idx].pred_target != res_target)));
  // an enqueue racing a mispredict belongs to the wrong path
  assign do_enq = enq_valid && enq_ready && !squash && !mis;
  assign err    = res_valid && !squash &&
                  (empty || (state != NORMAL) || (mem[rd_idx].pc != res_pc));

  always_ff @(posedge clk) begin
    if (do_enq)
      mem[wr_ptr[QAW-1:0]] <= '{pc: enq_pc, pred_take: enq_pred_take,
                                pred_target: enq_pred_target,
                                pht_index: enq_pht_index, ghr: enq_ghr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      state             <= NORMAL;
      cnt               <= '0;
      rst_done          <= 1'b0;
      mispredict        <= 1'b0;
      redirect_pc       <= '0;
      upd_valid         <= 1'b0;
      upd_pht_index     <= '0;
      upd_take          <= 1'b0;
      ghr_restore_valid <= 1'b0;
      ghr_restore       <= '0;
      order_err         <= 1'b0;
    end else begin
      rst_done          <= 1'b1;
      upd_valid         <= do_res;
      mispredict        <= mis;
      ghr_restore_valid <= mis;
      if (err) order_err <= 1'b1;

      if (do_res) begin
        upd_pht_index <= mem[rd_idx].pht_index;
        upd_take      <= res_take;
      end
      if (mis) begin
        ghr_restore <= {mem[rd_idx].ghr[PHT_DEPTH-2:0], res_take};
        redirect_pc <= res_take ? res_target : res_pc + 32'd8;  // +8 skips the delay slot
      end

      // queue pointers
      if (squash || mis) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_enq) wr_ptr <= wr_ptr + 1'b1;
        if (do_res) rd_ptr <= rd_ptr + 1'b1;
      end

      // recovery FSM
      if (squash) begin
        state <= NORMAL;
        cnt   <= '0;
      end else begin
        case (state)
          NORMAL: if (mis) begin
            state <= RECOVER;
            cnt   <= CW'(RECOVER_CYCLES - 1);
          end
          RECOVER: begin
            if (cnt == '0) state <= NORMAL;
            else           cnt   <= cnt - 1'b1;
          end
          default: state <= NORMAL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: reset, correct resolve, both kinds
// of mispredict with recovery, full/wrap behaviour, squash and order errors.
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enq_valid, enq_pred_take, enq_ready, squash;
  logic [31:0] enq_pc, enq_pred_target;
  logic [5:0]  enq_pht_index, enq_ghr;
  logic        res_valid, res_take;
  logic [31:0] res_pc, res_target;
  logic        mispredict, upd_valid, upd_take, ghr_restore_valid, flush_front, order_err;
  logic [31:0] redirect_pc;
  logic [5:0]  upd_pht_index, ghr_restore;
  logic [2:0]  occupancy;

  int tests = 0;
  int fails = 0;

  branch_resolve_queue #(.PHT_DEPTH(6), .QAW(2), .RECOVER_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_pred_take(enq_pred_take),
    .enq_pred_target(enq_pred_target), .enq_pht_index(enq_pht_index),
    .enq_ghr(enq_ghr), .enq_ready(enq_ready), .squash(squash),
    .res_valid(res_valid), .res_pc(res_pc), .res_take(res_take),
    .res_target(res_target), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pht_index(upd_pht_index), .upd_take(upd_take),
    .ghr_restore_valid(ghr_restore_valid), .ghr_restore(ghr_restore),
    .flush_front(flush_front), .occupancy(occupancy), .order_err(order_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic v, input logic [31:0] pc, input logic take,
                         input logic [31:0] tgt, input logic [5:0] idx, input logic [5:0] ghr);
    enq_valid = v; enq_pc = pc; enq_pred_take = take;
    enq_pred_target = tgt; enq_pht_index = idx; enq_ghr = ghr;
  endtask

  task automatic set_res(input logic v, input logic [31:0] pc, input logic take,
                         input logic [31:0] tgt);
    res_valid = v; res_pc = pc; res_take = take; res_target = tgt;
  endtask

  initial begin
    rst_n = 1'b0; squash = 1'b0;
    set_enq(0, 0, 0, 0, 0, 0);
    set_res(0, 0, 0, 0);

    // reset state
    #3;
    chk("rst_occupancy", occupancy, 0);
    chk("rst_flush", flush_front, 0);
    chk("rst_mispredict", mispredict, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_order_err", order_err, 0);
    chk("rst_enq_ready_low", enq_ready, 0);
    #9 rst_n = 1'b1;
    tick();
    chk("rst_enq_ready_high", enq_ready, 1);

    // correct taken prediction
    set_enq(1, 32'h100, 1, 32'h200, 6'h15, 6'h00);
    tick();
    set_enq(0, 0, 0, 0, 0, 0);
    chk("a_occ1", occupancy, 1);
    set_res(1, 32'h100, 1, 32'h200);
    tick();
    set_res(0, 0, 0, 0);
    chk("a_upd_valid", upd_valid, 1);
    chk("a_upd_idx", upd_pht_index, 6'h15);
    chk("a_upd_take", upd_take, 1);
    chk("a_mispredict", mispredict, 0);
    chk("a_occ0", occupancy, 0);
    tick();
    chk("a_upd_pulse_end", upd_valid, 0);

    // direction mispredict, taken; same-cycle enqueue must be discarded
    set_enq(1, 32'h40, 0, 32'h0, 6'h0A, 6'b101101);
    tick();
    set_enq(1, 32'h50, 0, 32'h0, 6'h0B, 6'h00);
    set_res(1, 32'h40, 1, 32'h80);
    tick();
    set_enq(0, 0, 0, 0, 0, 0);
    set_res(0, 0, 0, 0);
    chk("b_mispredict", mispredict, 1);
    chk("b_redirect", redirect_pc, 32'h80);
    chk("b_ghr_valid", ghr_restore_valid, 1);
    chk("b_ghr_restore", ghr_restore, 6'b011011);
    chk("b_upd_idx", upd_pht_index, 6'h0A);
    chk("b_flush1", flush_front, 1);
    chk("b_ready1", enq_ready, 0);
    chk("b_occ_cleared", occupancy, 0);
    tick();
    chk("b_mis_pulse_end", mispredict, 0);
    chk("b_flush2", flush_front, 1);
    chk("b_ready2", enq_ready, 0);
    tick();
    chk("b_flush_done", flush_front, 0);
    chk("b_ready_back", enq_ready, 1);
    chk("b_order_err", order_err, 0);

    // predicted taken, actually not taken: redirect to pc+8; reset mid-recovery
    set_enq(1, 32'h1F0, 1, 32'h300, 6'h21, 6'b000111);
    tick();
    set_enq(0, 0, 0, 0, 0, 0);
    set_res(1, 32'h1F0, 0, 32'h0);
    tick();
    set_res(0, 0, 0, 0);
    chk("c_mispredict", mispredict, 1);
    chk("c_redirect", redirect_pc, 32'h1F8);
    chk("c_ghr_restore", ghr_restore, 6'b001110);
    chk("c_upd_take", upd_take, 0);
    chk("c_flush", flush_front, 1);
    rst_n = 1'b0;
    #1;
    chk("c_rst_flush", flush_front, 0);
    chk("c_rst_mispredict", mispredict, 0);
    chk("c_rst_occ", occupancy, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("c_ready_after_rst", enq_ready, 1);

    // fill to full; 5th enqueue is dropped
    for (int i = 1; i <= 4; i++) begin
      set_enq(1, 32'h1000 + 32'(4 * (i - 1)), 0, 32'h0, 6'(i), 6'h00);
      tick();
    end
    chk("e_occ_full", occupancy, 4);
    chk("e_ready_full", enq_ready, 0);
    set_enq(1, 32'h1010, 0, 32'h0, 6'd5, 6'h00);
    tick();
    chk("e_drop", occupancy, 4);
    // resolve while full: enqueue still refused this cycle
    set_res(1, 32'h1000, 0, 32'h0);
    tick();
    chk("e_full_res_occ", occupancy, 3);
    chk("e_full_res_idx", upd_pht_index, 6'd1);
    // resolve + enqueue on 3 entries holds occupancy
    set_res(1, 32'h1004, 0, 32'h0);
    tick();
    chk("e_pair_occ", occupancy, 3);
    chk("e_pair_idx", upd_pht_index, 6'd2);
    // 10 more pairs: queue holds 3,4,5 then keeps cycling through wrap
    for (int i = 0; i < 10; i++) begin
      set_enq(1, 32'h1000 + 32'(4 * (5 + i)), 0, 32'h0, 6'(6 + i), 6'h00);
      set_res(1, 32'h1000 + 32'(4 * (2 + i)), 0, 32'h0);
      tick();
      chk($sformatf("e_wrap_idx%0d", i), upd_pht_index, 32'(3 + i));
      chk($sformatf("e_wrap_upd%0d", i), upd_valid, 1);
    end
    set_enq(0, 0, 0, 0, 0, 0);
    set_res(0, 0, 0, 0);
    chk("e_wrap_occ", occupancy, 3);
    chk("e_wrap_mis", mispredict, 0);
    chk("e_order_err", order_err, 0);

    // squash with 3 entries and a same-cycle resolve of the head (idx 13)
    squash = 1'b1;
    set_res(1, 32'h1030, 0, 32'h0);
    tick();
    squash = 1'b0;
    set_res(0, 0, 0, 0);
    chk("f_squash_occ", occupancy, 0);
    chk("f_squash_upd", upd_valid, 0);
    chk("f_squash_err", order_err, 0);

    // resolve on empty queue
    set_res(1, 32'h2000, 1, 32'h3000);
    tick();
    set_res(0, 0, 0, 0);
    chk("g_empty_err", order_err, 1);
    chk("g_empty_upd", upd_valid, 0);
    chk("g_empty_mis", mispredict, 0);
    squash = 1'b1;
    tick();
    squash = 1'b0;
    tick();
    chk("g_err_sticky", order_err, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Resolution end of the gshare prediction path. Fetch enqueues every predicted branch with its prediction context (PHT index, speculative GHR snapshot, predicted target). Memory stage resolves branches in program order.
- For each resolved branch the block compares the prediction against the actual outcome, then emits the PHT update, the GHR repair value and the front-end redirect/flush.
- Sits between the predictor/fetch stage and the M-stage branch unit. It replaces per-stage pred_take flops with one in-order tracking queue.

Parameters:
- PHT_DEPTH, 6, PHT index width; equals GHR width.
- QAW, 2, log2 of queue depth (depth = 1<<QAW entries).
- RECOVER_CYCLES, 2, cycles spent in RECOVER after a mispredict (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enq_valid  in  1  predicted branch issued in F.
- enq_pc  in  32  branch PC.
- enq_pred_take  in  1  predicted direction.
- enq_pred_target  in  32  predicted target; don't-care if not taken.
- enq_pht_index  in  PHT_DEPTH  PHT index used for the prediction.
- enq_ghr  in  PHT_DEPTH  speculative GHR value before this branch shifted in.
- enq_ready  out  1  queue can accept an entry.
- squash  in  1  exception flush; discards all in-flight entries.
- res_valid  in  1  oldest branch resolved in M.
- res_pc  in  32  PC of the resolved branch (ordering check).
- res_take  in  1  actual direction.
- res_target  in  32  actual taken target.
- mispredict  out  1  registered pulse: resolved branch was mispredicted.
- redirect_pc  out  32  correct fetch PC; valid with mispredict.
- upd_valid  out  1  registered pulse: PHT update request.
- upd_pht_index  out  PHT_DEPTH  PHT entry to train.
- upd_take  out  1  training direction.
- ghr_restore_valid  out  1  pulse with mispredict: load GHR_Spec.
- ghr_restore  out  PHT_DEPTH  {snapshot[PHT_DEPTH-2:0], res_take}.
- flush_front  out  1  high throughout RECOVER.
- occupancy  out  QAW+1  current entry count.
- order_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_n low, async):
  - Queue empty; rd/wr pointers 0; occupancy 0.
  - State NORMAL; all pulse outputs 0; redirect_pc 0, upd_pht_index 0, ghr_restore 0; order_err 0.
  - enq_ready rises only after reset deasserts.
- Queue:
  - Circular FIFO; pointers are QAW+1 bits.
  - Full when the pointer MSBs differ and the low bits are equal; empty when the pointers are equal. Wrap-around is by natural overflow.
- enq_ready = !full && state==NORMAL.
  - enq_valid && !enq_ready: entry dropped, no flag.
  - enq_valid && !enq_ready && squash: entry dropped, no flag.
- Enqueue and resolve in the same cycle are both legal, including when full (resolve frees the head, but enq_ready stays 0 that cycle) and when empty (resolve is an error; see below).
- Resolve, at cycle t with the queue non-empty and state NORMAL:
  - Pop the head.
  - At t+1 assert upd_valid=1, upd_pht_index=head.pht_index, upd_take=res_take.
  - Mispredict condition: head.pred_take!=res_take, OR (res_take && head.pred_target!=res_target).
  - If mispredicted, at t+1 also assert mispredict=1, ghr_restore_valid=1, ghr_restore={head.ghr[PHT_DEPTH-2:0],res_take}.
  - redirect_pc = res_take ? res_target : res_pc+8 (skips the delay slot).
  - On mispredict the whole queue is cleared at the t edge. A simultaneous enqueue is discarded. Next state is RECOVER.
- res_pc!=head.pc: order_err set. Normal resolve still proceeds.
- res_valid with the queue empty, or while in RECOVER: order_err set; no outputs; no state change.
- FSM:
  - NORMAL -> RECOVER on mispredict.
  - RECOVER lasts exactly RECOVER_CYCLES cycles (down-counter), with flush_front=1 and enq_ready=0, then returns to NORMAL.
- squash has priority over resolve and enqueue:
  - Queue cleared; any same-cycle resolve is ignored (no upd pulse); state forced to NORMAL.
  - Counter cleared; flush_front drops the next cycle.
  - order_err is unaffected.
- Pulse outputs are high for exactly one cycle per event.
- order_err clears only on reset.

Test Plan:
- Reset mid-RECOVER (rst_n low asynchronously) -> flush_front, occupancy, mispredict all 0 immediately; enq_ready 1 after release.
- Enqueue pc 0x100 pred_take=1 target 0x200 idx 0x15; resolve take=1 target 0x200 -> next cycle upd_valid=1 idx 0x15 take=1, mispredict 0, occupancy 1->0.
- Enqueue pc 0x40 pred_take=0 ghr 6'b101101; resolve take=1 target 0x80 -> mispredict=1, redirect_pc 0x80, ghr_restore 6'b011011; flush_front high 2 cycles; enq_ready 0 during those cycles.
- Pred_take=1 target 0x300, actual take=0 at pc 0x1F0 -> mispredict=1, redirect_pc 0x1F8.
- Fill 4 entries -> enq_ready 0, a 5th enq is dropped. Simultaneous resolve + enq on a 3-entry queue keeps occupancy at 3. Run 10 more enq/resolve pairs -> pointers wrap and the PHT index order is preserved.
- Resolve on empty queue -> order_err=1, no upd_valid. squash with 3 entries plus same-cycle res_valid -> occupancy 0, no upd_valid, order_err unchanged.
